// File: rtl/tile_ram_arbiter.sv
// tile_ram_arbiter: 8-phase tilemap SRAM arbiter with two video tile fetches and masked CPU slots.
// Define TILE_ARB_BLANK_CPU_EN to open every phase to the CPU and suppress video fetches during VBLANK.
module tile_ram_arbiter #(
  parameter logic [7:0] CPU_SLOT_MASK = 8'hF0
) (
  input  logic        CLK_6M,
  input  logic        RST_N,
  input  logic        HSYNC,
  input  logic        VBLANK,
  input  logic [10:0] TIDX_A,
  input  logic [10:0] TIDX_B,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [12:0] CPU_ADDR,
  input  logic [7:0]  CPU_WDATA,
  output logic        CPU_ACK,
  output logic [7:0]  CPU_RDATA,
  output logic [12:0] RAM_ADDR,
  output logic [7:0]  RAM_WDATA,
  input  logic [7:0]  RAM_RDATA,
  output logic        RAM_WE_N,
  output logic        RAM_OE_N,
  output logic [15:0] TILE_A,
  output logic [15:0] TILE_B,
  output logic        TILE_A_STB,
  output logic        TILE_B_STB,
  output logic [2:0]  PHASE
);
`ifdef TILE_ARB_BLANK_CPU_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif
  localparam logic [7:0] MASK = {CPU_SLOT_MASK[7:4], 4'h0};
  logic [2:0] phase_q, phase_d;
  logic hs_q, hs_d, grant_q, grant_d, ack_q, ack_d, vid_q, vid_d, b0_ok_q, b0_ok_d;
  logic stb_a_q, stb_a_d, stb_b_q, stb_b_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic [7:0] byte0_q, byte0_d, rdata_q, rdata_d, wdata_q, wdata_d;
  logic [15:0] tile_a_q, tile_a_d, tile_b_q, tile_b_d;
  logic [12:0] addr_q, addr_d;
  logic hs_edge, blank;
  assign blank = VBLANK & BLANK_EN;
  // RAM controls are registered for the phase being entered; read data is taken as that phase ends
  always_comb begin
    hs_edge = HSYNC & ~hs_q;
    hs_d = HSYNC;
    phase_d = hs_edge ? 3'd0 : phase_q + 3'd1;
    grant_d = (blank | MASK[phase_d]) & CPU_REQ & ~grant_q;
    vid_d = ~blank & ~phase_d[2];
    ack_d = grant_q;
    addr_d = grant_d ? CPU_ADDR : vid_d ? {phase_d[1], phase_d[1] ? TIDX_B : TIDX_A, phase_d[0]} : addr_q;
    we_n_d = ~(grant_d & CPU_WE);
    oe_n_d = ~(vid_d | (grant_d & ~CPU_WE));
    wdata_d = (grant_d & CPU_WE) ? CPU_WDATA : wdata_q;
    byte0_d = (vid_q & ~phase_q[0]) ? RAM_RDATA : byte0_q;
    b0_ok_d = vid_q & ~phase_q[0] & ~hs_edge;
    stb_a_d = vid_q & b0_ok_q & ~blank & (phase_q == 3'd1);
    stb_b_d = vid_q & b0_ok_q & ~blank & (phase_q == 3'd3);
    tile_a_d = stb_a_d ? {RAM_RDATA, byte0_q} : tile_a_q;
    tile_b_d = stb_b_d ? {RAM_RDATA, byte0_q} : tile_b_q;
    rdata_d = (grant_q & we_n_q) ? RAM_RDATA : rdata_q;
  end
  always_ff @(posedge CLK_6M or negedge RST_N)
    if (!RST_N) begin
      phase_q <= 3'd0;
      hs_q <= 1'b0;
      grant_q <= 1'b0;
      ack_q <= 1'b0;
      vid_q <= 1'b0;
      b0_ok_q <= 1'b0;
      stb_a_q <= 1'b0;
      stb_b_q <= 1'b0;
      we_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      byte0_q <= 8'h00;
      rdata_q <= 8'h00;
      wdata_q <= 8'h00;
      tile_a_q <= 16'h0000;
      tile_b_q <= 16'h0000;
      addr_q <= 13'h0000;
    end else begin
      phase_q <= phase_d;
      hs_q <= hs_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      vid_q <= vid_d;
      b0_ok_q <= b0_ok_d;
      stb_a_q <= stb_a_d;
      stb_b_q <= stb_b_d;
      we_n_q <= we_n_d;
      oe_n_q <= oe_n_d;
      byte0_q <= byte0_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      tile_a_q <= tile_a_d;
      tile_b_q <= tile_b_d;
      addr_q <= addr_d;
    end
  assign CPU_ACK = ack_q;
  assign CPU_RDATA = rdata_q;
  assign RAM_ADDR = addr_q;
  assign RAM_WDATA = wdata_q;
  assign RAM_WE_N = we_n_q;
  assign RAM_OE_N = oe_n_q;
  assign TILE_A = tile_a_q;
  assign TILE_B = tile_b_q;
  assign TILE_A_STB = stb_a_q;
  assign TILE_B_STB = stb_b_q;
  assign PHASE = phase_q;
endmodule
